// File: rtl/sd_seq_pkg.sv
// Shared types and register map for the SD command sequencer and its write engine.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    POLL,
    DONE,
    BOOT
  } seq_state_e;

  localparam logic [6:0] REG_TRIG = 7'd0;
  localparam logic [6:0] REG_ARG3 = 7'd1;
  localparam logic [6:0] REG_ARG2 = 7'd2;
  localparam logic [6:0] REG_ARG1 = 7'd3;
  localparam logic [6:0] REG_ARG0 = 7'd4;
  localparam logic [6:0] REG_CMD  = 7'd5;

  localparam int STAT_BUSY = 0;

  localparam logic [2:0] LAST_WR_IDX = 3'd5;

  // Fixed load order: command index, argument MSB..LSB, then the trigger.
  function automatic logic [6:0] reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_addr = REG_CMD;
      3'd1:    reg_addr = REG_ARG3;
      3'd2:    reg_addr = REG_ARG2;
      3'd3:    reg_addr = REG_ARG1;
      3'd4:    reg_addr = REG_ARG0;
      default: reg_addr = REG_TRIG;
    endcase
  endfunction

endpackage

// File: rtl/sd_reg_writer.sv
// Two-cycle SETUP/STROBE register write engine: one start loads and triggers a command
// with six writes; done pulses during the trigger strobe.
module sd_reg_writer
  import sd_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  output logic [6:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        done
);

  seq_state_e phase_q, phase_d;
  logic [2:0] idx_q, idx_d;
  logic       active;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase_q <= IDLE;
      idx_q   <= 3'd0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    done    = 1'b0;
    case (phase_q)
      IDLE: begin
        if (start) begin
          phase_d = SETUP;
          idx_d   = 3'd0;
        end
      end
      SETUP: phase_d = STROBE;
      STROBE: begin
        if (idx_q == LAST_WR_IDX) begin
          done    = 1'b1;
          phase_d = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          phase_d = SETUP;
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  // Address and data depend only on idx_q, so they cannot move while the strobe is high.
  always_comb begin
    active    = (phase_q == SETUP) || (phase_q == STROBE);
    bus_addr  = 7'd0;
    bus_wdata = 8'd0;
    bus_we    = (phase_q == STROBE);
    if (active) begin
      bus_addr = reg_addr(idx_q);
      case (idx_q)
        3'd0:    bus_wdata = {2'b00, cmd};
        3'd1:    bus_wdata = arg[31:24];
        3'd2:    bus_wdata = arg[23:16];
        3'd3:    bus_wdata = arg[15:8];
        3'd4:    bus_wdata = arg[7:0];
        default: bus_wdata = 8'd0;
      endcase
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Loads one SD command into the host controller, polls status until not busy or timeout,
// and returns a response beat. Optional power-up CMD0/CMD7 boot under SD_SEQ_BOOT_EN.
module sd_cmd_sequencer
  import sd_seq_pkg::*;
#(
  parameter int         POLL_DLY  = 8,
  parameter int         TIMEOUT   = 4096,
  parameter logic [6:0] STAT_ADDR = 7'd6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_cmd,
  input  logic [31:0] req_arg,
  output logic        resp_valid,
  output logic        resp_timeout,
  output logic [7:0]  resp_status,
  output logic [6:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  input  logic [7:0]  bus_rdata
`ifdef SD_SEQ_BOOT_EN
  ,
  input  logic [15:0] boot_rca,
  output logic        boot_done
`endif
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  // WAIT spans POLL_DLY-1 cycles so the first poll lands POLL_DLY cycles after the trigger.
  localparam int PW = (POLL_DLY > 2) ? $clog2(POLL_DLY - 1) : 1;
  localparam logic [PW-1:0] WAIT_LAST = (POLL_DLY >= 2) ? PW'(POLL_DLY - 2) : '0;
  localparam bit SKIP_WAIT = (POLL_DLY <= 1);

`ifdef SD_SEQ_BOOT_EN
  localparam seq_state_e RESET_STATE = BOOT;
`else
  localparam seq_state_e RESET_STATE = IDLE;
`endif

  seq_state_e    state_q, state_d;
  logic [5:0]    cmd_q, cmd_d;
  logic [31:0]   arg_q, arg_d;
  logic [PW-1:0] wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    status_q, status_d;

`ifdef SD_SEQ_BOOT_EN
  logic boot_act_q, boot_act_d;
  logic boot_step_q, boot_step_d;
  logic boot_done_q, boot_done_d;
`endif

  logic       wr_start;
  logic       wr_done;
  logic [6:0] wr_bus_addr;
  logic [7:0] wr_bus_wdata;
  logic       wr_bus_we;

  sd_reg_writer u_writer (
    .clk       (clk),
    .rstn      (rstn),
    .start     (wr_start),
    .cmd       (cmd_q),
    .arg       (arg_q),
    .bus_addr  (wr_bus_addr),
    .bus_wdata (wr_bus_wdata),
    .bus_we    (wr_bus_we),
    .done      (wr_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RESET_STATE;
      cmd_q      <= 6'd0;
      arg_q      <= 32'd0;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      status_q   <= 8'd0;
`ifdef SD_SEQ_BOOT_EN
      boot_act_q  <= 1'b1;
      boot_step_q <= 1'b0;
      boot_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
      status_q   <= status_d;
`ifdef SD_SEQ_BOOT_EN
      boot_act_q  <= boot_act_d;
      boot_step_q <= boot_step_d;
      boot_done_q <= boot_done_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
    status_d   = status_q;
`ifdef SD_SEQ_BOOT_EN
    boot_act_d  = boot_act_q;
    boot_step_d = boot_step_q;
    boot_done_d = boot_done_q;
`endif
    wr_start   = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    bus_addr   = wr_bus_addr;
    bus_wdata  = wr_bus_wdata;
    bus_we     = wr_bus_we;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cmd_d    = req_cmd;
          arg_d    = req_arg;
          wr_start = 1'b1;
          state_d  = SETUP;
        end
      end
`ifdef SD_SEQ_BOOT_EN
      BOOT: begin
        cmd_d    = boot_step_q ? 6'd7 : 6'd0;
        arg_d    = boot_step_q ? {boot_rca, 16'h0000} : 32'd0;
        wr_start = 1'b1;
        state_d  = SETUP;
      end
`endif
      // SETUP here covers the whole write burst; the writer owns the SETUP/STROBE phasing.
      SETUP: begin
        if (wr_done) begin
          wait_cnt_d = '0;
          to_cnt_d   = '0;
          state_d    = SKIP_WAIT ? POLL : WAIT;
        end
      end
      WAIT: begin
        bus_addr = STAT_ADDR;
        if (wait_cnt_q == WAIT_LAST) state_d = POLL;
        else wait_cnt_d = wait_cnt_q + PW'(1);
      end
      POLL: begin
        bus_addr = STAT_ADDR;
        if (!bus_rdata[STAT_BUSY]) begin
          status_d  = bus_rdata;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else if (to_cnt_q == TO_LAST) begin
          status_d  = bus_rdata;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
`ifdef SD_SEQ_BOOT_EN
      DONE: begin
        resp_valid = !boot_act_q;
        state_d    = IDLE;
        if (boot_act_q) begin
          if (timeout_q) begin
            boot_act_d = 1'b0;
          end else if (!boot_step_q) begin
            boot_step_d = 1'b1;
            state_d     = BOOT;
          end else begin
            boot_done_d = 1'b1;
            boot_act_d  = 1'b0;
          end
        end
      end
`else
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign resp_timeout = timeout_q;
  assign resp_status  = status_q;
`ifdef SD_SEQ_BOOT_EN
  assign boot_done = boot_done_q;
`endif

endmodule
